update_mask_scheduler: RTL and testbench

//  Shares one update_mask unit among NREQ requesters (attention heads/tiles) by round-robin.

---
 rtl/update_mask_pkg.sv | 27 ++
 rtl/update_mask_scheduler_rr_arbiter.sv | 37 +++
 rtl/update_mask_scheduler.sv | 146 ++++++++++++++
 tb/tb_update_mask_scheduler.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/update_mask_pkg.sv
// Shared definitions for the update_mask scheduler slice.
//   UM_*           encodings of update_mask.state
//   sched_state_t  scheduler FSM states
//   act_t          one signed activation value (IL integer + FL fraction bits)
//   act_vec_t      the 16-entry activation array handed to update_mask
package update_mask_pkg;

    localparam logic [1:0] UM_IDLE = 2'b00;
    localparam logic [1:0] UM_RUN  = 2'b01;
    localparam logic [1:0] UM_DONE = 2'b10;

    localparam int NACT   = 16;
    localparam int ACT_IL = 4;
    localparam int ACT_FL = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } sched_state_t;

    typedef logic signed [ACT_IL+ACT_FL-1:0] act_t;
    typedef act_t act_vec_t [NACT];

endpackage

// File: rtl/update_mask_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req  in   N     request vector
//   ptr  in   IW    highest-priority index for this cycle
//   gnt  out  N     one-hot grant (all zero when no request)
//   idx  out  IW    binary index of the granted request (0 when none)
// The priority pointer lives in the parent; this block only searches.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    // Walk N positions starting at ptr, wrapping at N; the first set
    // request wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/update_mask_scheduler.sv
// Shares one update_mask unit among NREQ requesters by round-robin.
// A granted job (mask + 16 activations + id) is latched, issued to
// update_mask via input_ready, the o_mask result is captured when the unit
// reports done, output_taken releases the unit, and the result is returned
// over a valid/ready response channel.
//   clk, reset               clock; asynchronous active-low reset
//   req_valid/req_ready      per-requester handshake, req_ready one-hot
//   req_mask, req_out        per-requester mask and activations (flat)
//   resp_valid/resp_ready    result handshake; resp_id, resp_mask payload
//   um_i_mask, um_out        job data to update_mask (held from latch)
//   um_input_ready           start strobe to update_mask
//   um_output_taken          one-cycle release strobe to update_mask
//   um_o_mask, um_state      result and status from update_mask
//   err                      sticky watchdog flag for a stuck update_mask
module update_mask_scheduler
    import update_mask_pkg::*;
#(
    parameter  int IL      = 4,
    parameter  int FL      = 16,
    parameter  int length  = 32,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = length + 8,
    localparam int AW      = IL + FL,
    localparam int OW      = NACT * AW,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*length-1:0] req_mask,
    input  logic [NREQ*OW-1:0]     req_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [length-1:0]      resp_mask,
    output logic [length-1:0]      um_i_mask,
    output logic [OW-1:0]          um_out,
    output logic                   um_input_ready,
    output logic                   um_output_taken,
    input  logic [length-1:0]      um_o_mask,
    input  logic [1:0]             um_state,
    output logic                   err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    sched_state_t      state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    job_id;
    logic [length-1:0] job_mask;
    logic [OW-1:0]     job_out;
    logic [length-1:0] result;
    logic [CW-1:0]     wait_cnt;

    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW-1:0]    ptr_next;
    logic [length-1:0] sel_mask;
    logic [OW-1:0]     sel_out;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign sel_mask = req_mask[int'(gnt_idx) * length +: length];
    assign sel_out  = req_out[int'(gnt_idx) * OW +: OW];
    assign ptr_next = (int'(gnt_idx) >= NREQ - 1) ? '0 : gnt_idx + IDW'(1);

    // Grants are only offered while idle; reset is folded in so the grant
    // vector reads zero during reset even if requesters keep valid high.
    assign req_ready       = (state == S_IDLE && reset) ? gnt : '0;
    assign um_input_ready  = (state == S_ISSUE) && (um_state == UM_IDLE);
    assign um_output_taken = (state == S_DRAIN);
    assign resp_valid      = (state == S_RESP);
    assign resp_id         = job_id;
    assign resp_mask       = result;
    assign um_i_mask       = job_mask;
    assign um_out          = job_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            job_id   <= '0;
            job_mask <= '0;
            job_out  <= '0;
            result   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        job_id   <= gnt_idx;
                        job_mask <= sel_mask;
                        job_out  <= sel_out;
                        rr_ptr   <= ptr_next;
                        // An all-zero mask cannot change, so skip the unit.
                        if (sel_mask == '0) begin
                            result <= '0;
                            state  <= S_RESP;
                        end else begin
                            state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (um_state == UM_IDLE) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // o_mask is captured here, before output_taken, because
                    // update_mask clears it while output_taken is high.
                    if (um_state == UM_DONE) begin
                        result <= um_o_mask;
                        state  <= S_DRAIN;
                    end
                    // Watchdog only flags; the FSM keeps waiting.
                    if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_update_mask_scheduler.sv
`timescale 1ns/1ps
module tb_update_mask_scheduler;
    import update_mask_pkg::*;

    localparam int NREQ = 4;
    localparam int LEN  = 32;
    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int AW   = IL + FL;
    localparam int OW   = NACT * AW;
    localparam int TMO  = LEN + 8;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*LEN-1:0]  req_mask = '0;
    logic [NREQ*OW-1:0]   req_out = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [IDW-1:0]       resp_id;
    logic [LEN-1:0]       resp_mask;
    logic [LEN-1:0]       um_i_mask;
    logic [OW-1:0]        um_out;
    logic                 um_input_ready;
    logic                 um_output_taken;
    logic [LEN-1:0]       um_o_mask;
    logic [1:0]           um_state;
    logic                 err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    update_mask_scheduler #(
        .IL(IL), .FL(FL), .length(LEN), .NREQ(NREQ), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mask(req_mask), .req_out(req_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_mask(resp_mask),
        .um_i_mask(um_i_mask), .um_out(um_out),
        .um_input_ready(um_input_ready), .um_output_taken(um_output_taken),
        .um_o_mask(um_o_mask), .um_state(um_state), .err(err)
    );

    // Reference rule for update_mask: activation k that is zero or negative
    // clears mask bit 16+k.
    function automatic logic [LEN-1:0] expect_mask(input logic [LEN-1:0] m, input logic [OW-1:0] o);
        logic [LEN-1:0] r;
        act_t a;
        r = m;
        for (int k = 0; k < NACT; k++) begin
            a = o[k*AW +: AW];
            if (a <= 0) r[16+k] = 1'b0;
        end
        return r;
    endfunction

    // Behavioural update_mask: runs LEN-1 cycles after the start strobe,
    // holds done until output_taken, can be told to hang.
    logic stub_hang = 1'b0;
    int   stub_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            um_state  <= UM_IDLE;
            stub_cnt  <= 0;
            um_o_mask <= '0;
        end else begin
            case (um_state)
                UM_IDLE: if (um_input_ready) begin
                    um_state <= UM_RUN;
                    stub_cnt <= 1;
                end
                UM_RUN: if (!stub_hang) begin
                    if (stub_cnt == LEN - 1) begin
                        um_state  <= UM_DONE;
                        um_o_mask <= expect_mask(um_i_mask, um_out);
                    end else begin
                        stub_cnt <= stub_cnt + 1;
                    end
                end
                UM_DONE: if (um_output_taken) begin
                    um_state  <= UM_IDLE;
                    um_o_mask <= '0;
                end
                default: um_state <= UM_IDLE;
            endcase
        end
    end

    // Cycle monitor, sampled just before each rising edge.
    int ir_pulses = 0;
    int ot_pulses = 0;
    int multi_rdy = 0;
    int busy_rdy  = 0;
    bit busy = 1'b0;
    always @(negedge clk) begin
        #4;
        if (reset) begin
            if (um_input_ready) ir_pulses++;
            if (um_output_taken) ot_pulses++;
            if ($countones(req_ready) > 1) multi_rdy++;
            if (req_ready != '0 && busy) busy_rdy++;
        end
    end

    logic [LEN-1:0] jm [NREQ];
    logic [OW-1:0]  jo [NREQ];
    int exp_ptr = 0;

    task automatic set_job(input int r, input logic [LEN-1:0] m, input logic [OW-1:0] o);
        jm[r] = m;
        jo[r] = o;
        req_mask[r*LEN +: LEN] = m;
        req_out[r*OW +: OW] = o;
    endtask

    function automatic logic [OW-1:0] rand_acts();
        logic [OW-1:0] o;
        for (int k = 0; k < NACT; k++) begin
            o[k*AW +: AW] = AW'($urandom);
            if ($urandom_range(0, 7) == 0) o[k*AW +: AW] = '0;
        end
        return o;
    endfunction

    function automatic logic [LEN-1:0] rand_nz_mask();
        logic [LEN-1:0] m;
        m = LEN'($urandom);
        if (m == '0) m = 1;
        return m;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // Raise req_valid and wait (bounded) for a grant to appear.
    task automatic issue(input logic [NREQ-1:0] v, output logic [NREQ-1:0] rdy, output bit to);
        req_valid = v;
        #1;
        to = 1'b1;
        rdy = '0;
        for (int c = 0; c < 100; c++) begin
            if (req_ready != '0) begin
                to = 1'b0;
                rdy = req_ready;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // Called at the first falling edge after the grant edge (j=0 there).
    task automatic wait_resp(output int j, output bit to);
        j = 0;
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (resp_valid) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
            j++;
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        busy = 1'b0;
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        busy = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        vectors++; if ({req_ready, resp_valid, um_input_ready, um_output_taken, err} !== '0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b required 0", {req_ready, resp_valid, um_input_ready, um_output_taken, err}); end
        vectors++; if ({resp_id, resp_mask} !== '0) begin
            miscompares++; $display("FAIL reset_resp: got id=%0d mask=%h required 0", resp_id, resp_mask); end
        vectors++; if ({um_i_mask, um_out} !== '0) begin
            miscompares++; $display("FAIL reset_um_data: got mask=%h out nonzero, required 0", um_i_mask); end
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [OW-1:0] o;
        logic [NREQ-1:0] rdy;
        bit to;
        int j, ir0, ot0;
        for (int k = 0; k < NACT; k++) o[k*AW +: AW] = AW'(k);
        set_job(0, 32'hFFFF_0000, o);
        ir0 = ir_pulses; ot0 = ot_pulses;
        issue(4'b0001, rdy, to);
        vectors++; if (to || rdy !== 4'b0001) begin
            miscompares++; $display("FAIL single_grant: got %b timeout=%0d required 0001", rdy, to); end
        @(negedge clk);
        req_valid = '0;
        busy = 1'b1;
        wait_resp(j, to);
        // Edge count includes the grant edge itself.
        vectors++; if (to || j + 1 != LEN + 3) begin
            miscompares++; $display("FAIL single_latency: got %0d edges timeout=%0d required %0d", j + 1, to, LEN + 3); end
        vectors++; if (resp_id !== 2'd0 || resp_mask !== 32'hFFFE_0000) begin
            miscompares++; $display("FAIL single_result: got id=%0d mask=%h required id=0 mask=fffe0000", resp_id, resp_mask); end
        vectors++; if (um_i_mask !== 32'hFFFF_0000) begin
            miscompares++; $display("FAIL single_held_mask: got %h required ffff0000", um_i_mask); end
        accept();
        vectors++; if (ir_pulses - ir0 != 1 || ot_pulses - ot0 != 1) begin
            miscompares++; $display("FAIL single_strobes: got ir=%0d ot=%0d required 1 1", ir_pulses - ir0, ot_pulses - ot0); end
        exp_ptr = 1;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] rdy;
        bit to;
        int j, m0, b0;
        pulse_reset();
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) set_job(r, rand_nz_mask(), rand_acts());
        m0 = multi_rdy; b0 = busy_rdy;
        for (int g = 0; g < 5; g++) begin
            issue(4'hF, rdy, to);
            vectors++; if (to || rdy !== NREQ'(1 << order[g])) begin
                miscompares++; $display("FAIL rr_grant%0d: got %b required %b", g, rdy, NREQ'(1 << order[g])); end
            @(negedge clk);
            busy = 1'b1;
            wait_resp(j, to);
            vectors++; if (to || resp_id !== IDW'(order[g]) || resp_mask !== expect_mask(jm[order[g]], jo[order[g]])) begin
                miscompares++; $display("FAIL rr_result%0d: got id=%0d mask=%h required id=%0d mask=%h", g, resp_id, resp_mask, order[g], expect_mask(jm[order[g]], jo[order[g]])); end
            accept();
        end
        req_valid = '0;
        exp_ptr = 1;
        vectors++; if (multi_rdy != m0 || busy_rdy != b0) begin
            miscompares++; $display("FAIL rr_ready_rules: got multi=%0d busy=%0d required 0 0", multi_rdy - m0, busy_rdy - b0); end
    endtask

    task automatic test_bypass();
        logic [NREQ-1:0] rdy;
        bit to;
        int j, ir0, ot0;
        set_job(2, '0, rand_acts());
        ir0 = ir_pulses; ot0 = ot_pulses;
        issue(4'b0100, rdy, to);
        vectors++; if (to || rdy !== 4'b0100) begin
            miscompares++; $display("FAIL bypass_grant: got %b required 0100", rdy); end
        @(negedge clk);
        req_valid = '0;
        busy = 1'b1;
        wait_resp(j, to);
        vectors++; if (to || j + 1 != 1 || resp_mask !== '0 || resp_id !== 2'd2) begin
            miscompares++; $display("FAIL bypass_result: got edges=%0d id=%0d mask=%h required 1 2 0", j + 1, resp_id, resp_mask); end
        accept();
        vectors++; if (ir_pulses != ir0 || ot_pulses != ot0) begin
            miscompares++; $display("FAIL bypass_no_unit: got ir=%0d ot=%0d required 0 0", ir_pulses - ir0, ot_pulses - ot0); end
        exp_ptr = 3;
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] rdy;
        logic [LEN-1:0] em;
        bit to;
        int j, ot0, b0, unstable;
        set_job(1, rand_nz_mask(), rand_acts());
        em = expect_mask(jm[1], jo[1]);
        ot0 = ot_pulses; b0 = busy_rdy;
        issue(4'b0010, rdy, to);
        vectors++; if (to || rdy !== 4'b0010) begin
            miscompares++; $display("FAIL bp_grant: got %b required 0010", rdy); end
        @(negedge clk);
        busy = 1'b1;
        req_valid = 4'b1101;
        wait_resp(j, to);
        unstable = to ? 1 : 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_mask !== em) unstable++;
        end
        vectors++; if (unstable != 0) begin
            miscompares++; $display("FAIL bp_stable: got %0d unstable cycles required 0", unstable); end
        vectors++; if (busy_rdy != b0 || ot_pulses - ot0 != 1) begin
            miscompares++; $display("FAIL bp_strobes: got ready_while_busy=%0d ot=%0d required 0 1", busy_rdy - b0, ot_pulses - ot0); end
        req_valid = '0;
        accept();
        exp_ptr = 2;
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] rdy;
        bit to;
        pulse_reset();
        @(negedge clk);
        stub_hang = 1'b1;
        set_job(0, rand_nz_mask(), rand_acts());
        issue(4'b0001, rdy, to);
        vectors++; if (to || rdy !== 4'b0001) begin
            miscompares++; $display("FAIL tmo_grant: got %b required 0001", rdy); end
        @(negedge clk);
        req_valid = '0;
        busy = 1'b1;
        repeat (TMO) @(negedge clk);
        vectors++; if (err !== 1'b0) begin
            miscompares++; $display("FAIL tmo_early: got err=%b required 0", err); end
        @(negedge clk);
        vectors++; if (err !== 1'b1) begin
            miscompares++; $display("FAIL tmo_set: got err=%b required 1", err); end
        repeat (20) @(negedge clk);
        vectors++; if (err !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL tmo_sticky: got err=%b resp_valid=%b required 1 0", err, resp_valid); end
        reset = 1'b0;
        #1;
        vectors++; if (err !== 1'b0) begin
            miscompares++; $display("FAIL tmo_clear: got err=%b required 0", err); end
        stub_hang = 1'b0;
        reset = 1'b1;
        busy = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [NREQ-1:0] rdy;
        logic [LEN-1:0] em;
        bit to;
        int j;
        set_job(1, rand_nz_mask(), rand_acts());
        issue(4'b0010, rdy, to);
        @(negedge clk);
        req_valid = '0;
        busy = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        vectors++; if ({req_ready, resp_valid, um_input_ready, um_output_taken, err, resp_id, resp_mask} !== '0) begin
            miscompares++; $display("FAIL arst_outputs: got valid=%b id=%0d mask=%h required 0", resp_valid, resp_id, resp_mask); end
        vectors++; if ({um_i_mask, um_out} !== '0) begin
            miscompares++; $display("FAIL arst_um_data: got mask=%h required 0", um_i_mask); end
        reset = 1'b1;
        busy = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        set_job(3, rand_nz_mask(), rand_acts());
        em = expect_mask(jm[3], jo[3]);
        issue(4'b1000, rdy, to);
        @(negedge clk);
        req_valid = '0;
        busy = 1'b1;
        wait_resp(j, to);
        vectors++; if (to || j + 1 != LEN + 3 || resp_id !== 2'd3 || resp_mask !== em) begin
            miscompares++; $display("FAIL arst_fresh_job: got edges=%0d id=%0d mask=%h required %0d 3 %h", j + 1, resp_id, resp_mask, LEN + 3, em); end
        accept();
        exp_ptr = 0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v, rdy;
        logic [LEN-1:0] em;
        bit to, mz;
        int w, j, d;
        for (int it = 0; it < 30; it++) begin
            for (int r = 0; r < NREQ; r++)
                set_job(r, ($urandom_range(0, 3) == 0) ? '0 : rand_nz_mask(), rand_acts());
            v = NREQ'($urandom_range(1, 15));
            w = rr_pick(v, exp_ptr);
            em = expect_mask(jm[w], jo[w]);
            mz = (jm[w] == '0);
            issue(v, rdy, to);
            vectors++; if (to || rdy !== NREQ'(1 << w)) begin
                miscompares++; $display("FAIL rnd_grant%0d: got %b required %b", it, rdy, NREQ'(1 << w)); end
            @(negedge clk);
            req_valid = '0;
            busy = 1'b1;
            // The job must already be latched; changing the inputs must not matter.
            set_job(w, rand_nz_mask(), rand_acts());
            wait_resp(j, to);
            vectors++; if (to || j + 1 != (mz ? 1 : LEN + 3)) begin
                miscompares++; $display("FAIL rnd_latency%0d: got %0d edges required %0d", it, j + 1, mz ? 1 : LEN + 3); end
            vectors++; if (resp_id !== IDW'(w)) begin
                miscompares++; $display("FAIL rnd_id%0d: got %0d required %0d", it, resp_id, w); end
            vectors++; if (resp_mask !== em) begin
                miscompares++; $display("FAIL rnd_mask%0d: got %h required %h", it, resp_mask, em); end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            accept();
            exp_ptr = (w + 1) % NREQ;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_bypass();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
